// File: rtl/function_mode_arbiter.sv
// function_mode_arbiter
// Shares the keyboard, SSD word bus and LED bus between three function
// controllers and sequences the active function (0 -> 1 -> 2 -> 0).
// Optional feature macro: MODE_BANNER_EN. When defined, each mode change
// shows an "F- n" banner for BANNER_CYCLES cycles, keys arriving during the
// banner are buffered in a FIFO_DEPTH-entry queue and replayed afterwards.
// When undefined, advance switches the mode directly and keys always pass
// straight through with one cycle of latency.
// All outputs are registered; reset is asynchronous, active low.
module function_mode_arbiter #(
   parameter int BANNER_CYCLES = 50_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        advance,
   input  logic [7:0]  keyPulse,
   input  logic [31:0] displayIn0,
   input  logic [31:0] displayIn1,
   input  logic [31:0] displayIn2,
   input  logic [15:0] ledIn0,
   input  logic [15:0] ledIn1,
   input  logic [15:0] ledIn2,
   output logic [31:0] wordOut,
   output logic [15:0] ledOut,
   output logic [7:0]  keyOut0,
   output logic [7:0]  keyOut1,
   output logic [7:0]  keyOut2,
   output logic [2:0]  enableOut,
   output logic [1:0]  mode,
   output logic        bannerActive,
   output logic        keyDropped
);

   // Reject parameter values the counter and queue pointers cannot represent.
   if (BANNER_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
      $error("function_mode_arbiter: BANNER_CYCLES must be >= 1, FIFO_DEPTH a power of two >= 2");
   end

   logic [1:0]  modeReg;
   logic [1:0]  modeNext;
   logic [1:0]  modeDec;
   logic [1:0]  modeInc;
   logic [7:0]  keyRoute;
   logic        bannerNext;
   logic        dropNext;
   logic [31:0] displaySel;
   logic [15:0] ledSel;
   logic [7:0]  keyOutArr [3];

   // The unused encoding 3 behaves as function 0.
   assign modeDec = (modeReg == 2'd3) ? 2'd0 : modeReg;

   // Successor in the 0 -> 1 -> 2 -> 0 rotation.
   always_comb begin
      case (modeDec)
         2'd0:    modeInc = 2'd1;
         2'd1:    modeInc = 2'd2;
         default: modeInc = 2'd0;
      endcase
   end

   // Select the active function's display and LED words.
   always_comb begin
      case (modeDec)
         2'd1: begin
            displaySel = displayIn1;
            ledSel     = ledIn1;
         end
         2'd2: begin
            displaySel = displayIn2;
            ledSel     = ledIn2;
         end
         default: begin
            displaySel = displayIn0;
            ledSel     = ledIn0;
         end
      endcase
   end

`ifdef MODE_BANNER_EN
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BANNER = 2'd1,
      DRAIN  = 2'd2
   } arbState_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(BANNER_CYCLES + 1);
   localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(BANNER_CYCLES - 1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

   arbState_t        stateReg;
   arbState_t        stateNext;
   logic [CNT_W-1:0] counterReg;
   logic [CNT_W-1:0] counterNext;
   logic [PTR_W-1:0] rdPtrReg;
   logic [PTR_W-1:0] rdPtrNext;
   logic [PTR_W-1:0] wrPtrReg;
   logic [PTR_W-1:0] wrPtrNext;
   logic [PTR_W:0]   countReg;
   logic [PTR_W:0]   countNext;
   logic             pendingReg;
   logic             pendingNext;
   logic             doPush;
   logic             doPop;
   logic             flush;
   logic             bannerDone;
   logic [7:0]       fifoMem [FIFO_DEPTH];

   // Sequencer state, banner counter, queue pointers and deferred advance.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stateReg   <= RUN;
         counterReg <= '0;
         rdPtrReg   <= '0;
         wrPtrReg   <= '0;
         countReg   <= '0;
         pendingReg <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         counterReg <= counterNext;
         rdPtrReg   <= rdPtrNext;
         wrPtrReg   <= wrPtrNext;
         countReg   <= countNext;
         pendingReg <= pendingNext;
      end
   end

   // Key queue storage; contents are only meaningful under countReg.
   always_ff @(posedge clk) begin
      if (doPush) begin
         fifoMem[wrPtrReg] <= keyPulse;
      end
   end

   // Next state, queue control and key routing.
   // The pop happens in the last banner cycle so the first replayed key
   // lands in the first cycle the banner is gone.
   always_comb begin
      stateNext   = stateReg;
      modeNext    = modeReg;
      counterNext = counterReg;
      rdPtrNext   = rdPtrReg;
      wrPtrNext   = wrPtrReg;
      countNext   = countReg;
      pendingNext = pendingReg;
      doPush      = 1'b0;
      doPop       = 1'b0;
      flush       = 1'b0;
      bannerDone  = 1'b0;
      keyRoute    = 8'd0;
      dropNext    = 1'b0;
      case (stateReg)
         RUN: begin
            keyRoute = keyPulse;
            if (advance) begin
               stateNext   = BANNER;
               modeNext    = modeInc;
               counterNext = RELOAD;
            end
         end
         BANNER: begin
            if (advance) begin
               // Keys queued for the mode being skipped are discarded silently.
               modeNext    = modeInc;
               counterNext = RELOAD;
               flush       = 1'b1;
            end else begin
               bannerDone = (counterReg == '0);
               doPop      = bannerDone && (countReg != '0);
               if (keyPulse != 8'd0) begin
                  if (countReg != FULL_COUNT || doPop) begin
                     doPush = 1'b1;
                  end else begin
                     dropNext = 1'b1;
                  end
               end
               if (!bannerDone) begin
                  counterNext = counterReg - CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (countReg == '0 && keyPulse == 8'd0) begin
               // A deferred advance takes effect in the cycle RUN would start.
               pendingNext = 1'b0;
               if (pendingReg || advance) begin
                  stateNext   = BANNER;
                  modeNext    = modeInc;
                  counterNext = RELOAD;
               end else begin
                  stateNext = RUN;
               end
            end else begin
               // New keys queue behind the buffered ones to keep order.
               pendingNext = pendingReg | advance;
               doPop       = (countReg != '0);
               doPush      = (keyPulse != 8'd0);
            end
         end
         default: stateNext = RUN;
      endcase

      if (doPop) begin
         keyRoute  = fifoMem[rdPtrReg];
         rdPtrNext = rdPtrReg + PTR_W'(1);
      end
      if (doPush) begin
         wrPtrNext = wrPtrReg + PTR_W'(1);
      end
      if (doPush && !doPop) begin
         countNext = countReg + (PTR_W + 1)'(1);
      end else if (doPop && !doPush) begin
         countNext = countReg - (PTR_W + 1)'(1);
      end
      if (flush) begin
         rdPtrNext = '0;
         wrPtrNext = '0;
         countNext = '0;
      end
      if (bannerDone) begin
         stateNext = (countNext != '0) ? DRAIN : RUN;
      end
      bannerNext = (stateNext == BANNER);
   end
`else
   // Without the banner, advance rotates the mode and keys pass straight through.
   always_comb begin
      modeNext   = advance ? modeInc : modeReg;
      keyRoute   = keyPulse;
      bannerNext = 1'b0;
      dropNext   = 1'b0;
   end
`endif

   // Mode register and registered display, LED, enable and status outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         modeReg      <= 2'd0;
         wordOut      <= 32'd0;
         ledOut       <= 16'd0;
         enableOut    <= 3'b001;
         bannerActive <= 1'b0;
         keyDropped   <= 1'b0;
      end else begin
         modeReg <= modeNext;
         if (bannerNext) begin
            wordOut   <= {8'h46, 8'h2D, 8'h20, 8'h31 + {6'd0, modeNext}};
            ledOut    <= {3'b001 << modeNext, 13'd0};
            enableOut <= 3'b000;
         end else begin
            wordOut   <= displaySel;
            ledOut    <= ledSel;
            enableOut <= 3'b001 << modeNext;
         end
         bannerActive <= bannerNext;
         keyDropped   <= dropNext;
      end
   end

   // One key register per function; only the active function sees the key.
   for (genvar gi = 0; gi < 3; gi++) begin : gKeyOut
      logic [7:0] keyReg;

      // Route the selected key to this function when it is the active one.
      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            keyReg <= 8'd0;
         end else begin
            keyReg <= (modeDec == 2'(gi)) ? keyRoute : 8'd0;
         end
      end

      assign keyOutArr[gi] = keyReg;
   end

   assign keyOut0 = keyOutArr[0];
   assign keyOut1 = keyOutArr[1];
   assign keyOut2 = keyOutArr[2];
   assign mode    = modeReg;

endmodule
